// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 4-digit 7-segment driver with frame-locked digit capture
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 25,
  parameter int ACTIVE_LOW   = 1,
  parameter int LZ_BLANK     = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] du,
  input  logic [3:0] dd,
  input  logic [3:0] su,
  input  logic [3:0] sd,
  input  logic       dp_en,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [3:0]    sh_du, sh_dd, sh_su, sh_sd;
  logic [FW-1:0] frame_cnt;
  logic          phase_on;

  logic          tick;
  logic          boundary;
  logic          phase_eff;
  logic [3:0]    digit;
  logic          blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign tick     = (scan_cnt == SCAN_LAST);
  assign boundary = tick && (idx == 2'd3);
  // Dropping blink relights the display on the very next edge, without waiting for phase_on.
  assign phase_eff = phase_on || !blink;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  // Shadow digits change only when the scan wraps back to digit 0, so a frame is never torn.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_du <= 4'd0;
      sh_dd <= 4'd0;
      sh_su <= 4'd0;
      sh_sd <= 4'd0;
    end else if (boundary) begin
      sh_du <= du;
      sh_dd <= dd;
      sh_su <= su;
      sh_sd <= sd;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!blink) begin
      frame_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (boundary) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        phase_on  <= !phase_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    digit = sh_du;
    case (idx)
      2'd0: digit = sh_du;
      2'd1: digit = sh_dd;
      2'd2: digit = sh_su;
      2'd3: digit = sh_sd;
      default: digit = sh_du;
    endcase
  end

  always_comb begin
    blank   = (LZ_BLANK != 0) && (idx == 2'd3) && (sh_sd == 4'd0);
    seg_nxt = blank ? 7'h00 : decode(digit);
    dp_nxt  = (idx == 2'd2) && dp_en;
    an_nxt  = phase_eff ? (4'b0001 << idx) : 4'b0000;
  end

  // Polarity is applied here so every output comes straight from a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= {4{POL}};
      seg <= {7{POL}};
      dp  <= POL;
    end else begin
      an  <= an_nxt ^ {4{POL}};
      seg <= seg_nxt ^ {7{POL}};
      dp  <= dp_nxt ^ POL;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] du = 4'd0, dd = 4'd0, su = 4'd0, sd = 4'd0;
  logic       dp_en = 1'b0;
  logic       blink = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  seg7_scan_driver #(
    .SCAN_DIV(4),
    .BLINK_FRAMES(2),
    .ACTIVE_LOW(1),
    .LZ_BLANK(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .du(du),
    .dd(dd),
    .su(su),
    .sd(sd),
    .dp_en(dp_en),
    .blink(blink),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 clock = ~clock;

  // Posedges since the last reset release; slot j of frame k is shown on edges 16k+4j+1..16k+4j+4.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc = 0;
    else        cyc = cyc + 1;
  end

  function automatic logic [6:0] lo(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'h3F; 4'd1: p = 7'h06; 4'd2: p = 7'h5B; 4'd3: p = 7'h4F;
      4'd4: p = 7'h66; 4'd5: p = 7'h6D; 4'd6: p = 7'h7D; 4'd7: p = 7'h07;
      4'd8: p = 7'h7F; 4'd9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return ~p;
  endfunction

  task automatic push_one(input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_t e;
    e.an = a; e.seg = s; e.dp = d;
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic [3:0] u0, input logic [3:0] t0, input logic [3:0] u1,
                            input logic [3:0] t1, input logic dpe, input logic lit);
    push_one(lit ? 4'hE : 4'hF, lo(u0), 1'b1);
    push_one(lit ? 4'hD : 4'hF, lo(t0), 1'b1);
    push_one(lit ? 4'hB : 4'hF, lo(u1), ~dpe);
    push_one(lit ? 4'h7 : 4'hF, (t1 == 4'd0) ? 7'h7F : lo(t1), 1'b1);
  endtask

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 2000) begin
      @(posedge clock); #1;
      guard++;
    end
    if (cyc < n) begin
      checks++;
      failures++;
      $error("FAIL goto_timeout cyc=%0d required=%0d", cyc, n);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard_empty an=%h seg=%h dp=%b", tag, an, seg, dp);
      return;
    end
    e = sb.pop_front();
    assert (an === e.an && seg === e.seg && dp === e.dp) else begin
      failures++;
      $error("FAIL %s got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
             tag, an, seg, dp, e.an, e.seg, e.dp);
    end
  endtask

  task automatic check_at(input int c, input string tag);
    goto(c);
    compare(tag);
  endtask

  task automatic check_frame(input int k, input string tag);
    for (int j = 0; j < 4; j++)
      check_at(16 * k + 4 * j + 2, $sformatf("%s_f%0d_s%0d", tag, k, j));
  endtask

  initial begin
    du = 4'd7; dd = 4'd3; su = 4'd5; sd = 4'd2; dp_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    push_one(4'hF, 7'h7F, 1'b1);
    compare("reset_state");

    @(negedge clock) reset = 1'b1;
    push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    check_frame(0, "zero_shadow");
    push_frame(4'd7, 4'd3, 4'd5, 4'd2, 1'b1, 1'b1);
    check_frame(1, "digits_7352");

    goto(31);
    su = 4'd9; sd = 4'd0;
    push_frame(4'd7, 4'd3, 4'd9, 4'd0, 1'b1, 1'b1);
    check_frame(2, "lz_blank");

    goto(47);
    du = 4'hA;
    push_frame(4'hA, 4'd3, 4'd9, 4'd0, 1'b1, 1'b1);
    check_frame(3, "bcd_invalid");

    goto(63);
    du = 4'd1;
    push_frame(4'd1, 4'd3, 4'd9, 4'd0, 1'b1, 1'b1);
    check_frame(4, "du1");

    push_frame(4'd1, 4'd3, 4'd9, 4'd0, 1'b1, 1'b1);
    check_at(82, "midframe_s0");
    check_at(86, "midframe_s1");
    du = 4'd2;
    check_at(90, "midframe_s2");
    check_at(94, "midframe_s3");
    push_frame(4'd2, 4'd3, 4'd9, 4'd0, 1'b1, 1'b1);
    check_frame(6, "after_boundary");

    goto(113);
    reset = 1'b0;
    #1;
    push_one(4'hF, 7'h7F, 1'b1);
    compare("reset_midscan");
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;

    push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    goto(1);
    blink = 1'b1;
    check_frame(0, "rst_scan");
    push_frame(4'd2, 4'd3, 4'd9, 4'd0, 1'b1, 1'b1);
    check_frame(1, "blink_on");
    push_frame(4'd2, 4'd3, 4'd9, 4'd0, 1'b1, 1'b0);
    check_frame(2, "blink_off");
    push_frame(4'd2, 4'd3, 4'd9, 4'd0, 1'b1, 1'b0);
    check_frame(3, "blink_off");
    push_frame(4'd2, 4'd3, 4'd9, 4'd0, 1'b1, 1'b1);
    check_frame(4, "blink_relit");

    push_one(4'hF, lo(4'd2), 1'b1);
    check_at(98, "blink_off_f6");
    goto(100);
    blink = 1'b0;
    push_one(4'hD, lo(4'd3), 1'b1);
    check_at(101, "unblink_next_cycle");
    push_frame(4'd2, 4'd3, 4'd9, 4'd0, 1'b1, 1'b1);
    check_frame(7, "unblinked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
